instr_mem_pipe: RTL and testbench

INSTR_MEM_PIPE -- requirements
Module: instr_mem_pipe

---
 rtl/instr_mem_pipe_if.sv | 34 +++
 rtl/instr_mem_pipe.sv | 134 +++++++++++++
 tb/tb_instr_mem_pipe.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_pipe_if.sv
// Fetch request/response channel for instr_mem_pipe.
// Each direction uses a valid/ready handshake.
interface instr_mem_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    modport master (
        output req_valid,
        output req_addr,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_err
    );
endinterface

// File: rtl/instr_mem_pipe.sv
// Instruction memory with a program-load port and a one-cycle fetch pipe.
// The memory is cleared word by word after reset, before any fetch is served.
module instr_mem_pipe #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_mem_pipe_if.slave   bus,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              init_done
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IDX_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_err;

    logic              w_ready;
    logic              w_accept;
    logic [IDX_W-1:0]  w_req_idx;
    logic              w_req_ok;
    logic [IDX_W-1:0]  w_ld_idx;
    logic              w_ld_ok;
    logic              w_we;
    logic [IDX_W-1:0]  w_widx;
    logic [DATA_W-1:0] w_wdata;

    // Aligned and below DEPTH words; any upper address bit set is out of range
    assign w_req_idx = bus.req_addr[IDX_W+1:2];
    assign w_req_ok  = (bus.req_addr[1:0] == 2'b00) &&
                       ((bus.req_addr >> (IDX_W + 2)) == '0);
    assign w_ld_idx  = ld_addr[IDX_W+1:2];
    assign w_ld_ok   = (ld_addr[1:0] == 2'b00) &&
                       ((ld_addr >> (IDX_W + 2)) == '0);

    assign w_accept  = bus.req_valid && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_INIT: begin
                if (r_cnt == IDX_W'(DEPTH - 1)) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_next = S_RUN;
            end
            default: begin
                w_next = S_INIT;
            end
        endcase
    end

    always_comb begin
        w_ready   = 1'b0;
        init_done = 1'b0;
        w_we      = 1'b0;
        w_widx    = '0;
        w_wdata   = '0;
        unique case (r_state)
            S_INIT: begin
                w_we   = 1'b1;
                w_widx = r_cnt;
            end
            S_RUN: begin
                init_done = 1'b1;
                w_ready   = !r_resp_valid || bus.resp_ready;
                w_we      = ld_en && w_ld_ok;
                w_widx    = w_ld_idx;
                w_wdata   = ld_data;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_INIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_widx] <= w_wdata;
        end
    end

    // The read samples the array before this edge's write lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_req_ok ? r_mem[w_req_idx] : '0;
            r_resp_err   <= !w_req_ok;
        end else if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_err   = r_resp_err;
endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed bench for instr_mem_pipe: clear timing, load/fetch ordering,
// error handling, back-pressure and reset abort.
module tb_instr_mem_pipe;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst_n;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              init_done;

    int n_chk;
    int n_err;

    instr_mem_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    instr_mem_pipe #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic resp(input string tag, input logic [DATA_W-1:0] d,
                        input logic e);
        check({tag, "_v"}, 32'(bus.resp_valid), 32'd1);
        check({tag, "_d"}, bus.resp_data, d);
        check({tag, "_e"}, 32'(bus.resp_err), 32'(e));
    endtask

    task automatic run_init(input string tag);
        for (int i = 0; i < DEPTH - 1; i++) begin
            tick();
            check({tag, "_busy"}, 32'(init_done), 32'd0);
            check({tag, "_rdy0"}, 32'(bus.req_ready), 32'd0);
        end
        tick();
        check({tag, "_done"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        ld_en          = 1'b0;
        ld_addr        = '0;
        ld_data        = '0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b1;

        tick();
        tick();
        check("rst_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_data", bus.resp_data, 32'd0);
        check("rst_err", 32'(bus.resp_err), 32'd0);
        check("rst_done", 32'(init_done), 32'd0);
        check("rst_rdy", 32'(bus.req_ready), 32'd0);

        // Pending fetch and load during clear: fetch must wait, load ignored
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0;
        ld_en         = 1'b1;
        ld_addr       = 32'h0;
        ld_data       = 32'hFFFF_FFFF;
        #2;
        rst_n = 1'b1;
        run_init("init");
        ld_en = 1'b0;
        check("init_rdy1", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        resp("f0", 32'h0, 1'b0);

        load(32'h8, 32'hDEAD_BEEF);
        check("idle_v", 32'(bus.resp_valid), 32'd0);
        fetch(32'h8);
        resp("f8a", 32'hDEAD_BEEF, 1'b0);

        // Same-cycle load and fetch return pre-write data
        ld_en         = 1'b1;
        ld_addr       = 32'h8;
        ld_data       = 32'h1234_5678;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8;
        tick();
        ld_en = 1'b0;
        resp("f8b", 32'hDEAD_BEEF, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        resp("f8c", 32'h1234_5678, 1'b0);

        load(32'h4, 32'hA5A5_A5A5);
        fetch(32'h6);
        resp("mis", 32'h0, 1'b1);
        fetch(32'(4 * DEPTH));
        resp("oor", 32'h0, 1'b1);
        load(32'h6, 32'h1111_1111);
        load(32'(4 * DEPTH), 32'h2222_2222);
        fetch(32'h4);
        resp("f4", 32'hA5A5_A5A5, 1'b0);
        fetch(32'h0);
        resp("f0b", 32'h0, 1'b0);

        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0;
        tick();
        resp("b2b0", 32'h0, 1'b0);
        bus.req_addr = 32'h4;
        tick();
        resp("b2b1", 32'hA5A5_A5A5, 1'b0);
        bus.req_addr = 32'h8;
        tick();
        resp("b2b2", 32'h1234_5678, 1'b0);
        bus.req_valid = 1'b0;
        tick();
        check("b2b_end", 32'(bus.resp_valid), 32'd0);

        // Back-pressure: held output, no accept, loads do not disturb it
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h8;
        tick();
        bus.req_addr = 32'h4;
        ld_en        = 1'b1;
        ld_addr      = 32'h8;
        ld_data      = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            tick();
            ld_en = 1'b0;
            resp("hold", 32'h1234_5678, 1'b0);
            check("hold_rdy", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        #1;
        check("rel_rdy", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        resp("rel", 32'hA5A5_A5A5, 1'b0);
        tick();
        check("rel_end", 32'(bus.resp_valid), 32'd0);
        fetch(32'h8);
        resp("f8d", 32'hCAFE_F00D, 1'b0);

        // Reset while a response is pending
        bus.resp_ready = 1'b0;
        fetch(32'h4);
        check("pre_rst_v", 32'(bus.resp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_v", 32'(bus.resp_valid), 32'd0);
        check("arst_d", bus.resp_data, 32'd0);
        check("arst_done", 32'(init_done), 32'd0);
        check("arst_rdy", 32'(bus.req_ready), 32'd0);
        bus.resp_ready = 1'b1;
        #2;
        rst_n = 1'b1;
        run_init("reinit");
        fetch(32'h8);
        resp("clr8", 32'h0, 1'b0);
        fetch(32'h4);
        resp("clr4", 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
